// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: FSM states, frame constants and the
// reflected CRC32 byte-update used by the FCS engine.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAD,
        FCS
    } fcs_state_t;

    localparam int          ETH_MIN_LEN   = 60;
    localparam int          FCS_BYTES     = 4;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;

    // LSB-first update, one data bit per iteration
    function automatic logic [31:0] crc32_byte(
        input logic [31:0] crc,
        input logic [7:0]  data
    );
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i])
                c = (c >> 1) ^ CRC32_POLY;
            else
                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_fcs_tx_ctrl_crc.sv
// Byte-wide CRC32 engine. crc_next is the state after absorbing data,
// exposed so the sequencer can capture the final value on the same edge.
module eth_fcs_tx_ctrl_crc
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] crc;

    assign crc_next = crc32_byte(crc, data);

    always_ff @(posedge clk) begin
        if (reset || clear)
            crc <= CRC32_INIT;
        else if (enable)
            crc <= crc_next;
    end

endmodule

// File: rtl/eth_fcs_tx_ctrl.sv
// TX FCS sequencer: forwards payload, optionally zero-pads to MIN_LEN
// (ETH_FCS_PAD_EN), then appends the 4-byte FCS LSB first.
module eth_fcs_tx_ctrl
    import eth_pkg::*;
#(
    parameter int MIN_LEN = ETH_MIN_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy
);

    localparam logic [15:0] MIN_CNT = 16'(MIN_LEN);

    fcs_state_t  state, state_nx;
    logic [15:0] cnt, cnt_nx, cnt_inc;
    logic [1:0]  fcs_idx, fcs_idx_nx;
    logic [31:0] fcs, fcs_nx;
    logic [7:0]  fcs_byte;
    logic [7:0]  data_nx;
    logic        valid_nx, last_nx;
    logic        slot, take_in, done;
    logic        crc_en, crc_clr;
    logic [7:0]  crc_data;
    logic [31:0] crc_next;

`ifndef ETH_FCS_PAD_EN
    logic unused_min;
    assign unused_min = ^MIN_CNT;
`endif

    // output register is free when empty or being drained this cycle
    assign slot     = !out_valid || out_ready;
    assign in_ready = !reset && (state == IDLE || state == DATA) && slot;
    assign take_in  = in_valid && in_ready;
    assign done     = (state == FCS) && out_valid && out_last && out_ready;
    assign busy     = (state != IDLE);
    assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign fcs_byte = fcs[{fcs_idx, 3'b000} +: 8];
    assign crc_data = (state == PAD) ? 8'h00 : in_data;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        fcs_idx_nx = fcs_idx;
        fcs_nx     = fcs;
        data_nx    = out_data;
        valid_nx   = out_valid && !out_ready;
        last_nx    = out_last;
        crc_en     = 1'b0;
        crc_clr    = 1'b0;
        unique case (state)
            IDLE, DATA: begin
                if (take_in) begin
                    crc_en   = 1'b1;
                    cnt_nx   = cnt_inc;
                    data_nx  = in_data;
                    valid_nx = 1'b1;
                    last_nx  = 1'b0;
                    state_nx = DATA;
                    if (in_last) begin
`ifdef ETH_FCS_PAD_EN
                        if (cnt_inc < MIN_CNT) begin
                            state_nx = PAD;
                        end else begin
                            state_nx   = FCS;
                            fcs_nx     = ~crc_next;
                            fcs_idx_nx = 2'd0;
                        end
`else
                        state_nx   = FCS;
                        fcs_nx     = ~crc_next;
                        fcs_idx_nx = 2'd0;
`endif
                    end
                end
            end
`ifdef ETH_FCS_PAD_EN
            PAD: begin
                if (slot) begin
                    crc_en   = 1'b1;
                    cnt_nx   = cnt_inc;
                    data_nx  = 8'h00;
                    valid_nx = 1'b1;
                    last_nx  = 1'b0;
                    if (cnt_inc >= MIN_CNT) begin
                        state_nx   = FCS;
                        fcs_nx     = ~crc_next;
                        fcs_idx_nx = 2'd0;
                    end
                end
            end
`endif
            FCS: begin
                if (done) begin
                    // engine cleared on IDLE entry so the next frame
                    // can start from a fresh state one cycle later
                    state_nx = IDLE;
                    cnt_nx   = 16'd0;
                    crc_clr  = 1'b1;
                    valid_nx = 1'b0;
                    last_nx  = 1'b0;
                end else if (slot) begin
                    data_nx    = fcs_byte;
                    valid_nx   = 1'b1;
                    last_nx    = (fcs_idx == 2'(FCS_BYTES - 1));
                    fcs_idx_nx = fcs_idx + 2'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            fcs_idx   <= 2'd0;
            fcs       <= 32'd0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            fcs_idx   <= fcs_idx_nx;
            fcs       <= fcs_nx;
            out_data  <= data_nx;
            out_valid <= valid_nx;
            out_last  <= last_nx;
        end
    end

    eth_fcs_tx_ctrl_crc u_crc (
        .clk      (clk),
        .reset    (reset),
        .clear    (crc_clr),
        .enable   (crc_en),
        .data     (crc_data),
        .crc_next (crc_next)
    );

endmodule

// File: tb/tb_eth_fcs_tx_ctrl.sv
// Bench for eth_fcs_tx_ctrl: random frames and back-pressure checked
// against a frame-level model (payload, pad, ~CRC32 LSB first).
module tb_eth_fcs_tx_ctrl;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       busy;

    always #5 clk = ~clk;

    eth_fcs_tx_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bq_t  in_q;
    logic inl_q[$];
    bq_t  exp_q;
    logic expl_q[$];
    bq_t  got_q;
    int   start_cyc[$];
    int   done_cyc[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // plain reflected CRC32 register (init all ones, no final inversion)
    function automatic logic [31:0] model_crc(input bq_t b);
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        foreach (b[i]) begin
            r = r ^ {24'd0, b[i]};
            repeat (8) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    task automatic add_frame(input bq_t p);
        bq_t         f;
        logic [31:0] r;
        f = p;
        foreach (p[i]) begin
            in_q.push_back(p[i]);
            inl_q.push_back(i == p.size() - 1);
        end
`ifdef ETH_FCS_PAD_EN
        while (f.size() < 60) f.push_back(8'h00);
`endif
        r = ~model_crc(f);
        for (int i = 0; i < 4; i++) f.push_back(r[8*i +: 8]);
        foreach (f[i]) begin
            exp_q.push_back(f[i]);
            expl_q.push_back(i == f.size() - 1);
        end
    endtask

    function automatic bq_t rand_payload(input int n);
        bq_t p;
        for (int i = 0; i < n; i++) p.push_back(8'($urandom));
        return p;
    endfunction

    task automatic run(input int ready_pct, input int abort_after,
                       input int budget);
        int          n_in;
        logic        pv, pl, prev_last;
        logic [7:0]  pd;
        bq_t         cur;
        n_in = 0;
        pv = 1'b0;
        pl = 1'b0;
        pd = 8'h00;
        prev_last = 1'b1;
        got_q.delete();
        start_cyc.delete();
        done_cyc.delete();
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            @(negedge clk);
            cyc++;
            if (abort_after > 0 && n_in >= abort_after) return;
            in_valid  = (in_q.size() > 0);
            in_data   = in_valid ? in_q[0] : 8'($urandom);
            in_last   = in_valid ? inl_q[0] : 1'b0;
            out_ready = ($urandom_range(99) < ready_pct);
            #1;
            if (pv) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(pd));
                check("hold_last", 32'(out_last), 32'(pl));
            end
            if (in_valid && in_ready) begin
                if (prev_last) start_cyc.push_back(cyc);
                prev_last = inl_q[0];
                void'(in_q.pop_front());
                void'(inl_q.pop_front());
                n_in++;
            end
            if (out_valid && out_ready) begin
                check("out_data", 32'(out_data), 32'(exp_q[0]));
                check("out_last", 32'(out_last), 32'(expl_q[0]));
                void'(exp_q.pop_front());
                void'(expl_q.pop_front());
                got_q.push_back(out_data);
                cur.push_back(out_data);
                if (out_last) begin
                    done_cyc.push_back(cyc);
                    check("residue", model_crc(cur), 32'hDEBB20E3);
                    cur.delete();
                end
            end
            pv = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
        end
        if (abort_after == 0)
            check("timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bq_t p, ref_q;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // "123456789" check frame
        p = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        add_frame(p);
        run(100, 0, 3000);
`ifdef ETH_FCS_PAD_EN
        check("check_len", 32'(got_q.size()), 32'd64);
`else
        check("check_len", 32'(got_q.size()), 32'd13);
        if (got_q.size() == 13) begin
            check("check_fcs0", 32'(got_q[9]), 32'h26);
            check("check_fcs1", 32'(got_q[10]), 32'h39);
            check("check_fcs2", 32'(got_q[11]), 32'hF4);
            check("check_fcs3", 32'(got_q[12]), 32'hCB);
        end
`endif

        // 64-byte frame, full rate then 50% back-pressure
        p = rand_payload(64);
        add_frame(p);
        run(100, 0, 3000);
        ref_q = got_q;
        add_frame(p);
        run(50, 0, 3000);
        check("stall_len", 32'(got_q.size()), 32'(ref_q.size()));
        if (got_q.size() == ref_q.size())
            foreach (ref_q[i]) check("stall_seq", 32'(got_q[i]), 32'(ref_q[i]));

        // back-to-back 60-byte frames, in_valid held high
        add_frame(rand_payload(60));
        add_frame(rand_payload(60));
        run(100, 0, 3000);
        check("b2b_frames", 32'(done_cyc.size()), 32'd2);
        check("b2b_gap",
              (start_cyc.size() > 1 && done_cyc.size() > 0) ?
              32'(start_cyc[1] - done_cyc[0]) : 32'hFFFFFFFF, 32'd1);

        // abort at byte 20, then a clean frame
        add_frame(rand_payload(40));
        run(100, 20, 3000);
        check("abort_busy", 32'(busy), 32'd1);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("abort_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_last", 32'(out_last), 32'd0);
        check("abort_busy_low", 32'(busy), 32'd0);
        reset = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        in_q.delete();
        inl_q.delete();
        exp_q.delete();
        expl_q.delete();
        add_frame(rand_payload(int'($urandom_range(1, 80))));
        run(50, 0, 3000);

        // assorted lengths including very short frames
        for (int k = 0; k < 6; k++) begin
            add_frame(rand_payload(int'($urandom_range(1, 100))));
            run(int'($urandom_range(30, 100)), 0, 3000);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
